layer9_label_trainer: RTL and testbench

- Sequencer on the target side of a 9-neuron learning layer.
- Accepts labelled samples over a valid/ready handshake and runs a forward pass, holding layer `valid` high with `learn` low.
- Classifies the layer's 9 outputs by argmax and reports the class and whether it was correct.
- For training samples, then drives one-hot `expected_out` targets with `learn` high.
- Keeps saturating sample and correct counters; sits between the testbench or host sample source and the layer's `expected_out` input.

---
 rtl/layer9_label_trainer.sv | 177 +++++++++++++++++
 tb/tb_layer9_label_trainer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer9_label_trainer.sv
// rtl/layer9_label_trainer.sv - target-side sequencer for a 9-neuron learning layer
//
// Accepts labelled samples and runs a forward pass on the layer (valid high,
// learn low). It then scores the layer outputs by argmax and, for training
// samples, drives one-hot zero2one_t targets with learn high. Saturating
// sample/correct counters track accuracy.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready         sample handshake; s_label (0..8), s_train
//   valid, learn            layer control strobes
//   expected_out[9][8]      per-neuron targets to the layer
//   out[9][8]               layer outputs
//   r_valid                 one-cycle result strobe
//   r_class, r_correct,     argmax class, match flag and out-of-range label
//   r_bad_label             flag; all held until the next score
//   clear                   synchronous counter clear
//   sample_count,           saturating 16-bit counters
//   correct_count
module layer9_label_trainer #(
    parameter int         LAT          = 1,
    parameter int         LEARN_CYCLES = 1,
    parameter logic [7:0] TGT_HI       = 8'hE6,
    parameter logic [7:0] TGT_LO       = 8'h1A
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [3:0]      s_label,
    input  logic            s_train,
    output logic            valid,
    output logic            learn,
    output logic [8:0][7:0] expected_out,
    input  logic [8:0][7:0] out,
    output logic            r_valid,
    output logic [3:0]      r_class,
    output logic            r_correct,
    output logic            r_bad_label,
    input  logic            clear,
    output logic [15:0]     sample_count,
    output logic [15:0]     correct_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_WAIT,
        S_SCORE,
        S_LEARN
    } state_t;

    localparam logic [3:0] LAT_CNT   = 4'(LAT);
    localparam logic [3:0] LEARN_CNT = 4'(LEARN_CYCLES);

    state_t          state;
    logic [3:0]      cnt;
    logic [3:0]      label_q;
    logic            train_q;
    logic [3:0]      best_idx;
    logic [7:0]      best_val;
    logic [8:0][7:0] targets;
    logic            label_ok;
    logic            class_hit;

    // Argmax with strict '>' so equal outputs resolve to the lowest index.
    always_comb begin
        best_idx = 4'd0;
        best_val = out[0];
        for (int i = 1; i < 9; i++) begin
            if (out[i] > best_val) begin
                best_val = out[i];
                best_idx = 4'(i);
            end
        end
    end

    always_comb begin
        targets = '0;
        for (int i = 0; i < 9; i++) begin
            targets[i] = (label_q == 4'(i)) ? TGT_HI : TGT_LO;
        end
    end

    assign label_ok  = (label_q <= 4'd8);
    assign class_hit = (best_idx == label_q) && label_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            s_ready       <= 1'b1;
            valid         <= 1'b0;
            learn         <= 1'b0;
            expected_out  <= '0;
            r_valid       <= 1'b0;
            r_class       <= 4'd0;
            r_correct     <= 1'b0;
            r_bad_label   <= 1'b0;
            sample_count  <= 16'd0;
            correct_count <= 16'd0;
            cnt           <= 4'd0;
            label_q       <= 4'd0;
            train_q       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s_valid && s_ready) begin
                        label_q <= s_label;
                        train_q <= s_train;
                        s_ready <= 1'b0;
                        valid   <= 1'b1;
                        state   <= S_FWD;
                    end
                end
                S_FWD: begin
                    valid <= 1'b0;
                    cnt   <= LAT_CNT;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // WAIT lasts LAT cycles; the layer output is settled by SCORE.
                    if (cnt <= 4'd1) begin
                        state <= S_SCORE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_SCORE: begin
                    r_valid     <= 1'b1;
                    r_class     <= best_idx;
                    r_correct   <= class_hit;
                    r_bad_label <= !label_ok;
                    if (sample_count != 16'hFFFF) begin
                        sample_count <= sample_count + 16'd1;
                    end
                    if (class_hit && (correct_count != 16'hFFFF)) begin
                        correct_count <= correct_count + 16'd1;
                    end
                    if (train_q && label_ok) begin
                        valid        <= 1'b1;
                        learn        <= 1'b1;
                        expected_out <= targets;
                        cnt          <= LEARN_CNT;
                        state        <= S_LEARN;
                    end else begin
                        s_ready <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_LEARN: begin
                    if (cnt <= 4'd1) begin
                        valid        <= 1'b0;
                        learn        <= 1'b0;
                        expected_out <= '0;
                        s_ready      <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b1;
                    valid   <= 1'b0;
                    learn   <= 1'b0;
                end
            endcase
            // Placed after the score update so a coincident clear takes priority.
            if (clear) begin
                sample_count  <= 16'd0;
                correct_count <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_layer9_label_trainer.sv
// tb/tb_layer9_label_trainer.sv - self-checking bench for layer9_label_trainer
module tb_layer9_label_trainer;

    localparam int LAT = 2;
    localparam int LC  = 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [3:0]      s_label = 4'd0;
    logic            s_train = 1'b0;
    logic            valid;
    logic            learn;
    logic [8:0][7:0] expected_out;
    logic [8:0][7:0] out_v = '0;
    logic            r_valid;
    logic [3:0]      r_class;
    logic            r_correct;
    logic            r_bad_label;
    logic            clear = 1'b0;
    logic [15:0]     sample_count;
    logic [15:0]     correct_count;

    int errors = 0;
    int checks = 0;
    int m_samples = 0;
    int m_correct = 0;

    layer9_label_trainer #(.LAT(LAT), .LEARN_CYCLES(LC), .TGT_HI(8'hE6), .TGT_LO(8'h1A)) dut (
        .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_label(s_label), .s_train(s_train), .valid(valid), .learn(learn),
        .expected_out(expected_out), .out(out_v), .r_valid(r_valid), .r_class(r_class),
        .r_correct(r_correct), .r_bad_label(r_bad_label), .clear(clear),
        .sample_count(sample_count), .correct_count(correct_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference class: find the largest value, then the first index holding it.
    function automatic int ref_class(input logic [8:0][7:0] v);
        int mx = 0;
        for (int i = 0; i < 9; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
        for (int i = 0; i < 9; i++) if (int'(v[i]) == mx) return i;
        return 0;
    endfunction

    function automatic logic [71:0] ref_tgt(input int lab);
        logic [71:0] t = '0;
        for (int i = 0; i < 9; i++) t[i*8 +: 8] = (i == lab) ? 8'hE6 : 8'h1A;
        return t;
    endfunction

    task automatic score_model(input bit corr, input bit clr);
        if (clr) begin
            m_samples = 0;
            m_correct = 0;
        end else begin
            if (m_samples < 65535) m_samples++;
            if (corr && m_correct < 65535) m_correct++;
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!s_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk(tag, 72'(s_ready), 72'(1));
    endtask

    task automatic run_sample(input logic [3:0] lab, input logic tr, input bit clr);
        int  exp_cls;
        bit  ok_lab;
        bit  exp_corr;
        bit  early;
        exp_cls  = ref_class(out_v);
        ok_lab   = (lab < 4'd9);
        exp_corr = ok_lab && (exp_cls == int'(lab));
        wait_ready("ready_before");
        s_valid = 1'b1;
        s_label = lab;
        s_train = tr;
        @(negedge clock);
        s_valid = 1'b0;
        s_label = 4'($urandom);
        s_train = 1'($urandom);
        chk("fwd_valid", 72'(valid), 72'(1));
        chk("fwd_learn", 72'(learn), 72'(0));
        chk("fwd_ready", 72'(s_ready), 72'(0));
        early = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clock);
            early = early | r_valid | valid | s_ready;
            if (i == LAT + 1 && clr) clear = 1'b1;
        end
        chk("wait_quiet", 72'(early), 72'(0));
        @(negedge clock);
        clear = 1'b0;
        score_model(exp_corr, clr);
        chk("r_valid", 72'(r_valid), 72'(1));
        chk("r_class", 72'(r_class), 72'(exp_cls));
        chk("r_correct", 72'(r_correct), 72'(exp_corr));
        chk("r_bad_label", 72'(r_bad_label), 72'(!ok_lab));
        chk("sample_count", 72'(sample_count), 72'(m_samples));
        chk("correct_count", 72'(correct_count), 72'(m_correct));
        if (tr && ok_lab) begin
            for (int j = 0; j < LC; j++) begin
                if (j > 0) chk("r_valid_pulse", 72'(r_valid), 72'(0));
                chk("learn_hi", 72'(learn), 72'(1));
                chk("learn_valid", 72'(valid), 72'(1));
                chk("learn_tgt", 72'(expected_out), ref_tgt(int'(lab)));
                @(negedge clock);
            end
            chk("learn_end", 72'(learn), 72'(0));
            chk("tgt_end", 72'(expected_out), 72'(0));
            chk("ready_after", 72'(s_ready), 72'(1));
        end else begin
            chk("no_learn", 72'(learn), 72'(0));
            chk("no_valid", 72'(valid), 72'(0));
            chk("ready_after", 72'(s_ready), 72'(1));
            @(negedge clock);
            chk("r_valid_pulse", 72'(r_valid), 72'(0));
            chk("r_class_hold", 72'(r_class), 72'(exp_cls));
        end
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 9; i++) out_v[i] = base;
    endtask

    initial begin
        int lab;
        int k;
        bit got;
        bit acc;

        // Reset state
        #12;
        chk("rst_ready", 72'(s_ready), 72'(1));
        chk("rst_valid", 72'(valid), 72'(0));
        chk("rst_learn", 72'(learn), 72'(0));
        chk("rst_tgt", 72'(expected_out), 72'(0));
        chk("rst_rvalid", 72'(r_valid), 72'(0));
        chk("rst_rbits", 72'({r_class, r_correct, r_bad_label}), 72'(0));
        chk("rst_counts", 72'({sample_count, correct_count}), 72'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Inference, correct
        fill(8'h40); out_v[3] = 8'hC0;
        run_sample(4'd3, 1'b0, 1'b0);

        // Training, wrong class
        fill(8'h10); out_v[2] = 8'hF0;
        run_sample(4'd5, 1'b1, 1'b0);

        // Tie resolves to lowest index
        fill(8'h20); out_v[1] = 8'h80; out_v[7] = 8'h80;
        run_sample(4'd7, 1'b1, 1'b0);

        // Bad label with train requested
        fill(8'h30); out_v[4] = 8'h90;
        run_sample(4'd12, 1'b1, 1'b0);

        // Randomised samples
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 9; i++) out_v[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                out_v[$urandom_range(0, 8)] = 8'hFF;
                out_v[$urandom_range(0, 8)] = 8'hFF;
            end
            lab = $urandom_range(0, 11);
            if ($urandom_range(0, 2) == 0 && lab < 9) lab = ref_class(out_v);
            run_sample(4'(lab), 1'($urandom), 1'b0);
        end

        // Clear coinciding with SCORE
        fill(8'h05); out_v[0] = 8'h50;
        run_sample(4'd0, 1'b0, 1'b1);

        // Saturation from a preloaded count
        @(negedge clock);
        force dut.sample_count = 16'hFFFE;
        force dut.correct_count = 16'hFFFE;
        @(posedge clock);
        #1;
        release dut.sample_count;
        release dut.correct_count;
        m_samples = 65534;
        m_correct = 65534;
        @(negedge clock);
        fill(8'h11); out_v[6] = 8'h99;
        for (int n = 0; n < 3; n++) run_sample(4'd6, 1'b0, 1'b0);
        chk("sat_counts", 72'({sample_count, correct_count}), 72'(32'hFFFF_FFFF));
        run_sample(4'd6, 1'b1, 1'b1);
        chk("clear_counts", 72'({sample_count, correct_count}), 72'(0));

        // Backpressure: s_valid held through the busy period
        wait_ready("bp_ready");
        fill(8'h22); out_v[2] = 8'hAA;
        s_valid = 1'b1; s_label = 4'd2; s_train = 1'b0;
        @(negedge clock);
        chk("bp_fwd", 72'(valid), 72'(1));
        acc = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clock);
            acc = acc | s_ready | valid;
        end
        chk("bp_blocked", 72'(acc), 72'(0));
        @(negedge clock);
        score_model(1'b1, 1'b0);
        chk("bp_rvalid", 72'(r_valid), 72'(1));
        chk("bp_ready_back", 72'(s_ready), 72'(1));
        s_label = 4'd6;
        @(negedge clock);
        chk("bp_second_fwd", 72'(valid), 72'(1));
        chk("bp_second_busy", 72'(s_ready), 72'(0));
        s_valid = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            @(negedge clock);
            got = r_valid;
            k++;
        end
        chk("bp_second_done", 72'(got), 72'(1));
        score_model(1'b0, 1'b0);
        chk("bp_second_correct", 72'(r_correct), 72'(0));
        chk("bp_counts", 72'({sample_count, correct_count}), 72'({16'(m_samples), 16'(m_correct)}));

        // Reset abort during LEARN
        wait_ready("abort_ready");
        fill(8'h01); out_v[8] = 8'h77;
        s_valid = 1'b1; s_label = 4'd0; s_train = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < 20) begin
            @(negedge clock);
            got = learn;
            k++;
        end
        chk("abort_learn_seen", 72'(got), 72'(1));
        reset_n = 1'b0;
        #1;
        m_samples = 0;
        m_correct = 0;
        chk("abort_learn", 72'(learn), 72'(0));
        chk("abort_valid", 72'(valid), 72'(0));
        chk("abort_tgt", 72'(expected_out), 72'(0));
        chk("abort_ready", 72'(s_ready), 72'(1));
        chk("abort_counts", 72'({sample_count, correct_count}), 72'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("abort_no_trail", 72'({learn, valid, r_valid}), 72'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
